// File: rtl/proc_pkg.sv
// ---------------------------------------------------------------------------
// proc_pkg
//  Shared types and constants for the 5-stage core hazard controller.
//  - fwd_sel_t  : EX operand source select (reg file / M ALU data / WB data)
//  - sb_entry_t : one scoreboard slot describing an in-flight instruction
//  - REG_ZERO   : architectural zero register address
//  - writes_reg : "this slot writes register a" test used by stall and forward
//  Addresses are stored at SB_AW bits.  Narrower core addresses are
//  zero-extended on entry, so any AW up to SB_AW works unchanged.
// ---------------------------------------------------------------------------
package proc_pkg;

   localparam int SB_AW = 8;

   localparam logic [SB_AW-1:0] REG_ZERO = '0;

   typedef enum logic [1:0] {
      FWD_REG = 2'b00,
      FWD_MEM = 2'b01,
      FWD_WB  = 2'b10
   } fwd_sel_t;

   // raddr is REG_ZERO for instructions that do not write a register, and
   // rs/rt are REG_ZERO for sources that are not read.  That folds the
   // "writes" and "used" qualifiers into the address compare itself.
   typedef struct packed {
      logic             valid;
      logic [SB_AW-1:0] raddr;
      logic [SB_AW-1:0] rs;
      logic [SB_AW-1:0] rt;
      logic             load;
   } sb_entry_t;

   // A slot is a relevant writer of register a when it is valid, its
   // destination is not r0, and the destination equals a.
   function automatic logic writes_reg(input logic             valid,
                                       input logic [SB_AW-1:0] raddr,
                                       input logic [SB_AW-1:0] a);
      return valid && (raddr != REG_ZERO) && (raddr == a);
   endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// ---------------------------------------------------------------------------
// hazard_fwd_sel
//  Forward-source select for one EX operand.  The M-stage writer is younger
//  than the W-stage writer, so it wins when both match.  A load in M has no
//  data yet on the ALU path, so it is never a forward source from M.
//  Ports:
//   src      in   EX operand source address (REG_ZERO when unused)
//   m_valid  in   M slot valid
//   m_raddr  in   M slot destination (REG_ZERO when not writing)
//   m_load   in   M slot is a load
//   w_valid  in   W slot valid
//   w_raddr  in   W slot destination (REG_ZERO when not writing)
//   sel      out  FWD_REG / FWD_MEM / FWD_WB
// ---------------------------------------------------------------------------
module hazard_fwd_sel
   import proc_pkg::*;
(
   input  logic [SB_AW-1:0] src,
   input  logic             m_valid,
   input  logic [SB_AW-1:0] m_raddr,
   input  logic             m_load,
   input  logic             w_valid,
   input  logic [SB_AW-1:0] w_raddr,
   output fwd_sel_t         sel
);

   always_comb begin
      sel = FWD_REG;
      if (writes_reg(m_valid, m_raddr, src) && !m_load) begin
         sel = FWD_MEM;
      end else if (writes_reg(w_valid, w_raddr, src)) begin
         sel = FWD_WB;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//  Pipeline hazard controller for the 5-stage core.  Tracks the instructions
//  in E, M and W in a 3-slot scoreboard, stalls on load-use (or on any RAW
//  when forwarding is disabled), freezes the front end while a multi-cycle
//  multiply occupies EX, flushes on a taken branch resolved in EX, and
//  drives the EX operand forward selects.
//  All outputs are combinational from the scoreboard / multiply counter and
//  the D-stage inputs of the same cycle.
//  Parameters:
//   AW       register-address width (<= SB_AW)
//   MUL_LAT  EX cycles per multiply, >= 1 (1 = no freeze)
//   FWD_EN   1 = forward M/W -> EX, 0 = stall on every RAW against E/M/W
//  Ports:
//   Clock, nReset               clock, async active-low reset
//   ValidD .. MULOpD            D-stage instruction description
//   BranchTakenE                taken branch/jump resolved in EX
//   StallF, StallD, StallE      hold PC / IF-ID / ID-EX and EX operands
//   FlushD                      IF-ID becomes a bubble next edge
//   BubbleE, BubbleM            ID-EX / EX-MEM loads a bubble next edge
//   ForwardA, ForwardB          EX operand source: 00 reg, 01 M, 10 WB
// ---------------------------------------------------------------------------
module hazard_ctrl
   import proc_pkg::*;
#(
   parameter int AW      = 5,
   parameter int MUL_LAT = 3,
   parameter int FWD_EN  = 1
)(
   input  logic          Clock,
   input  logic          nReset,
   input  logic          ValidD,
   input  logic [AW-1:0] RsAddrD,
   input  logic [AW-1:0] RtAddrD,
   input  logic          RsUsedD,
   input  logic          RtUsedD,
   input  logic [AW-1:0] RAddrD,
   input  logic          RegWriteD,
   input  logic          MemReadD,
   input  logic          MULOpD,
   input  logic          BranchTakenE,
   output logic          StallF,
   output logic          StallD,
   output logic          StallE,
   output logic          FlushD,
   output logic          BubbleE,
   output logic          BubbleM,
   output logic [1:0]    ForwardA,
   output logic [1:0]    ForwardB
);

   // Counter holds values 0 .. MUL_LAT-1.
   localparam int              MC_W     = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
   localparam logic [MC_W-1:0] MUL_LOAD = MC_W'(MUL_LAT - 1);

   sb_entry_t       sb_e_q, sb_e_d;
   sb_entry_t       sb_m_q, sb_m_d;
   sb_entry_t       sb_w_q, sb_w_d;
   logic [MC_W-1:0] mul_cnt_q, mul_cnt_d;

   sb_entry_t d_entry;
   logic      mul_busy;
   logic      load_use;
   logic      raw_any;
   logic      hazard;

   logic      stall_f, stall_d, stall_e, flush_d, bubble_e, bubble_m;
   fwd_sel_t  fwd_a, fwd_b;

   // Source-field bits of the older slots are carried for a uniform slot
   // layout but only the E slot's sources are ever compared.
   logic      unused_sb_bits;
   assign unused_sb_bits = ^{sb_m_q.rs, sb_m_q.rt, sb_w_q.rs, sb_w_q.rt, sb_w_q.load};

   // ------------------------------------------------------------------
   // D-stage slot image: what enters E when ID/EX advances.
   // ------------------------------------------------------------------
   always_comb begin
      d_entry = '0;
      if (ValidD) begin
         d_entry.valid = 1'b1;
         d_entry.raddr = RegWriteD ? SB_AW'(RAddrD)  : REG_ZERO;
         d_entry.rs    = RsUsedD   ? SB_AW'(RsAddrD) : REG_ZERO;
         d_entry.rt    = RtUsedD   ? SB_AW'(RtAddrD) : REG_ZERO;
         d_entry.load  = MemReadD;
      end
   end

   // ------------------------------------------------------------------
   // Hazard detection.  r0 never matches because writes_reg rejects it.
   // ------------------------------------------------------------------
   assign mul_busy = (mul_cnt_q != '0);

   assign load_use = sb_e_q.load &&
                     (writes_reg(sb_e_q.valid, sb_e_q.raddr, d_entry.rs) ||
                      writes_reg(sb_e_q.valid, sb_e_q.raddr, d_entry.rt));

   assign raw_any  = writes_reg(sb_e_q.valid, sb_e_q.raddr, d_entry.rs) ||
                     writes_reg(sb_e_q.valid, sb_e_q.raddr, d_entry.rt) ||
                     writes_reg(sb_m_q.valid, sb_m_q.raddr, d_entry.rs) ||
                     writes_reg(sb_m_q.valid, sb_m_q.raddr, d_entry.rt) ||
                     writes_reg(sb_w_q.valid, sb_w_q.raddr, d_entry.rs) ||
                     writes_reg(sb_w_q.valid, sb_w_q.raddr, d_entry.rt);

   // The multiply freeze already holds D, so a dependent instruction waits
   // behind it without a separate hazard stall.
   assign hazard = ValidD && ((FWD_EN != 0) ? load_use : raw_any) && !mul_busy;

   // ------------------------------------------------------------------
   // Pipeline control, priority: taken branch > multiply freeze > hazard.
   // A taken branch is never resolved while EX is frozen by a multiply.
   // ------------------------------------------------------------------
   always_comb begin
      stall_f  = 1'b0;
      stall_d  = 1'b0;
      stall_e  = 1'b0;
      flush_d  = 1'b0;
      bubble_e = 1'b0;
      bubble_m = 1'b0;
      if (BranchTakenE) begin
         flush_d  = 1'b1;
         bubble_e = 1'b1;
      end else if (mul_busy) begin
         stall_f  = 1'b1;
         stall_d  = 1'b1;
         stall_e  = 1'b1;
         bubble_m = 1'b1;
      end else if (hazard) begin
         stall_f  = 1'b1;
         stall_d  = 1'b1;
         bubble_e = 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Scoreboard and multiply counter next state.
   // W always retires M.  With EX held, M receives a bubble and E keeps the
   // multiply; otherwise everything shifts and E takes D (or a bubble).
   // ------------------------------------------------------------------
   always_comb begin
      sb_w_d = sb_m_q;
      if (stall_e) begin
         sb_m_d = '0;
         sb_e_d = sb_e_q;
      end else begin
         sb_m_d = sb_e_q;
         sb_e_d = bubble_e ? sb_entry_t'('0) : d_entry;
      end
   end

   always_comb begin
      mul_cnt_d = mul_cnt_q;
      if (mul_busy) begin
         mul_cnt_d = mul_cnt_q - MC_W'(1);
      end else if (!stall_e && !bubble_e && ValidD && MULOpD) begin
         // The first EX cycle of the multiply is the edge it enters E, so
         // the remaining freeze is MUL_LAT-1 cycles.
         mul_cnt_d = MUL_LOAD;
      end
   end

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         sb_e_q    <= '0;
         sb_m_q    <= '0;
         sb_w_q    <= '0;
         mul_cnt_q <= '0;
      end else begin
         sb_e_q    <= sb_e_d;
         sb_m_q    <= sb_m_d;
         sb_w_q    <= sb_w_d;
         mul_cnt_q <= mul_cnt_d;
      end
   end

   // ------------------------------------------------------------------
   // Operand forwarding for the instruction currently in E.
   // ------------------------------------------------------------------
   hazard_fwd_sel u_fwd_a (
      .src     (sb_e_q.rs),
      .m_valid (sb_m_q.valid),
      .m_raddr (sb_m_q.raddr),
      .m_load  (sb_m_q.load),
      .w_valid (sb_w_q.valid),
      .w_raddr (sb_w_q.raddr),
      .sel     (fwd_a)
   );

   hazard_fwd_sel u_fwd_b (
      .src     (sb_e_q.rt),
      .m_valid (sb_m_q.valid),
      .m_raddr (sb_m_q.raddr),
      .m_load  (sb_m_q.load),
      .w_valid (sb_w_q.valid),
      .w_raddr (sb_w_q.raddr),
      .sel     (fwd_b)
   );

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign StallF   = stall_f;
   assign StallD   = stall_d;
   assign StallE   = stall_e;
   assign FlushD   = flush_d;
   assign BubbleE  = bubble_e;
   assign BubbleM  = bubble_m;
   assign ForwardA = (FWD_EN != 0) ? fwd_a : FWD_REG;
   assign ForwardB = (FWD_EN != 0) ? fwd_b : FWD_REG;

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
//  Two hazard_ctrl instances share one D-stage stimulus stream:
//   u_fw : FWD_EN=1, MUL_LAT=3
//   u_nf : FWD_EN=0, MUL_LAT=3
//  A pipeline model (E/M/W records plus a freeze counter per instance) gives
//  the expected output word every cycle; directed checks pin the scenarios.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

   localparam int AW = 5;
   localparam int ML = 3;

   // ---------------- clock / reset ----------------
   logic Clock  = 1'b0;
   logic nReset = 1'b0;
   always #5 Clock = ~Clock;

   // ---------------- D-stage inputs ----------------
   logic          ValidD       = 1'b0;
   logic [AW-1:0] RsAddrD      = '0;
   logic [AW-1:0] RtAddrD      = '0;
   logic          RsUsedD      = 1'b0;
   logic          RtUsedD      = 1'b0;
   logic [AW-1:0] RAddrD       = '0;
   logic          RegWriteD    = 1'b0;
   logic          MemReadD     = 1'b0;
   logic          MULOpD       = 1'b0;
   logic          BranchTakenE = 1'b0;

   // ---------------- DUT outputs ----------------
   logic       fw_stall_f, fw_stall_d, fw_stall_e, fw_flush_d, fw_bubble_e, fw_bubble_m;
   logic [1:0] fw_fwd_a, fw_fwd_b;
   logic       nf_stall_f, nf_stall_d, nf_stall_e, nf_flush_d, nf_bubble_e, nf_bubble_m;
   logic [1:0] nf_fwd_a, nf_fwd_b;
   logic [9:0] got_fw, got_nf;

   assign got_fw = {fw_stall_f, fw_stall_d, fw_stall_e, fw_flush_d, fw_bubble_e, fw_bubble_m,
                    fw_fwd_a, fw_fwd_b};
   assign got_nf = {nf_stall_f, nf_stall_d, nf_stall_e, nf_flush_d, nf_bubble_e, nf_bubble_m,
                    nf_fwd_a, nf_fwd_b};

   hazard_ctrl #(.AW(AW), .MUL_LAT(ML), .FWD_EN(1)) u_fw (
      .Clock(Clock), .nReset(nReset), .ValidD(ValidD),
      .RsAddrD(RsAddrD), .RtAddrD(RtAddrD), .RsUsedD(RsUsedD), .RtUsedD(RtUsedD),
      .RAddrD(RAddrD), .RegWriteD(RegWriteD), .MemReadD(MemReadD), .MULOpD(MULOpD),
      .BranchTakenE(BranchTakenE),
      .StallF(fw_stall_f), .StallD(fw_stall_d), .StallE(fw_stall_e), .FlushD(fw_flush_d),
      .BubbleE(fw_bubble_e), .BubbleM(fw_bubble_m), .ForwardA(fw_fwd_a), .ForwardB(fw_fwd_b)
   );

   hazard_ctrl #(.AW(AW), .MUL_LAT(ML), .FWD_EN(0)) u_nf (
      .Clock(Clock), .nReset(nReset), .ValidD(ValidD),
      .RsAddrD(RsAddrD), .RtAddrD(RtAddrD), .RsUsedD(RsUsedD), .RtUsedD(RtUsedD),
      .RAddrD(RAddrD), .RegWriteD(RegWriteD), .MemReadD(MemReadD), .MULOpD(MULOpD),
      .BranchTakenE(BranchTakenE),
      .StallF(nf_stall_f), .StallD(nf_stall_d), .StallE(nf_stall_e), .FlushD(nf_flush_d),
      .BubbleE(nf_bubble_e), .BubbleM(nf_bubble_m), .ForwardA(nf_fwd_a), .ForwardB(nf_fwd_b)
   );

   // ---------------- scoreboard counters ----------------
   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // ---------------- pipeline model ----------------
   // Each record is an instruction in flight; dst is 0 for non-writers and
   // sa/sb are 0 for unread sources, so r0 never matches anything.
   typedef struct {
      bit v;
      int dst;
      int sa;
      int sb;
      bit ld;
   } mrec_t;

   mrec_t pipe  [2][3];   // [instance][0=E,1=M,2=W]
   mrec_t nxt   [2][3];
   int    freeze  [2];    // remaining frozen EX cycles
   int    nfreeze [2];

   function automatic mrec_t empty_rec();
      mrec_t r;
      r.v = 0; r.dst = 0; r.sa = 0; r.sb = 0; r.ld = 0;
      return r;
   endfunction

   // Youngest writer that can supply data for register r to E.
   function automatic int pick(input int k, input int r);
      if (r == 0) return 0;
      if (pipe[k][1].v && !pipe[k][1].ld && pipe[k][1].dst == r) return 1;
      if (pipe[k][2].v && pipe[k][2].dst == r) return 2;
      return 0;
   endfunction

   task automatic model_eval(input int k, output logic [9:0] ev);
      bit    fwd, busy, dep, haz;
      bit    sf, sd, se, fl, be, bm;
      int    fa, fb;
      int    srcs [2];
      mrec_t dr;
      fwd  = (k == 0);
      busy = (freeze[k] > 0);
      srcs[0] = (ValidD && RsUsedD) ? int'(RsAddrD) : 0;
      srcs[1] = (ValidD && RtUsedD) ? int'(RtAddrD) : 0;
      dep = 0;
      for (int j = 0; j < 2; j++) begin
         if (srcs[j] != 0) begin
            for (int s = 0; s < 3; s++) begin
               if (pipe[k][s].v && pipe[k][s].dst == srcs[j]) begin
                  if (!fwd || (s == 0 && pipe[k][s].ld)) dep = 1;
               end
            end
         end
      end
      haz = ValidD && dep && !busy;
      sf = 0; sd = 0; se = 0; fl = 0; be = 0; bm = 0;
      if (BranchTakenE) begin
         fl = 1; be = 1;
      end else if (busy) begin
         sf = 1; sd = 1; se = 1; bm = 1;
      end else if (haz) begin
         sf = 1; sd = 1; be = 1;
      end
      fa = fwd ? pick(k, pipe[k][0].sa) : 0;
      fb = fwd ? pick(k, pipe[k][0].sb) : 0;
      ev = {sf, sd, se, fl, be, bm, 2'(fa), 2'(fb)};

      dr = empty_rec();
      if (ValidD) begin
         dr.v   = 1;
         dr.dst = RegWriteD ? int'(RAddrD) : 0;
         dr.sa  = srcs[0];
         dr.sb  = srcs[1];
         dr.ld  = MemReadD;
      end
      nxt[k][2] = pipe[k][1];
      if (se) begin
         nxt[k][1] = empty_rec();
         nxt[k][0] = pipe[k][0];
      end else begin
         nxt[k][1] = pipe[k][0];
         nxt[k][0] = be ? empty_rec() : dr;
      end
      if (busy) nfreeze[k] = freeze[k] - 1;
      else if (!se && !be && ValidD && MULOpD) nfreeze[k] = ML - 1;
      else nfreeze[k] = 0;
   endtask

   always @(posedge Clock or negedge nReset) begin
      for (int k = 0; k < 2; k++) begin
         for (int s = 0; s < 3; s++) begin
            pipe[k][s] = nReset ? nxt[k][s] : empty_rec();
         end
         freeze[k] = nReset ? nfreeze[k] : 0;
      end
   end

   // Per-cycle compare, away from the active edge.
   always @(negedge Clock) begin
      logic [9:0] ev;
      for (int k = 0; k < 2; k++) begin
         model_eval(k, ev);
         if (k == 0) chk("cycle_fw", 16'(got_fw), 16'(ev));
         else        chk("cycle_nf", 16'(got_nf), 16'(ev));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic set_d(input bit v, input int rd, input bit we, input int rs, input bit rsu,
                        input int rt, input bit rtu, input bit ld, input bit mul);
      ValidD    = v;
      RAddrD    = AW'(rd);
      RegWriteD = we;
      RsAddrD   = AW'(rs);
      RsUsedD   = rsu;
      RtAddrD   = AW'(rt);
      RtUsedD   = rtu;
      MemReadD  = ld;
      MULOpD    = mul;
   endtask

   task automatic nop_d();
      set_d(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic tick();
      @(posedge Clock); #1;
   endtask

   task automatic mid();
      @(negedge Clock); #1;
   endtask

   task automatic nops(input int n);
      nop_d();
      repeat (n) tick();
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #100000;
      n_fail++;
      $display("FAIL watchdog: time limit reached");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      int n_all, n_any;
      for (int k = 0; k < 2; k++) begin
         for (int s = 0; s < 3; s++) begin
            pipe[k][s] = empty_rec();
            nxt[k][s]  = empty_rec();
         end
         freeze[k]  = 0;
         nfreeze[k] = 0;
      end

      // Reset state
      repeat (2) tick();
      mid();
      chk("reset_fw", 16'(got_fw), 16'h0);
      chk("reset_nf", 16'(got_nf), 16'h0);
      tick();
      nReset = 1'b1;
      nops(2);

      // 1: lw r2 ; add r3,r4,r2 -> one load-use stall, then ForwardB=WB
      set_d(1, 2, 1, 1, 1, 0, 0, 1, 0);
      tick();
      set_d(1, 3, 1, 4, 1, 2, 1, 0, 0);
      mid();
      chk("t1_stall_f",  16'(fw_stall_f), 16'h1);
      chk("t1_stall_d",  16'(fw_stall_d), 16'h1);
      chk("t1_bubble_e", 16'(fw_bubble_e), 16'h1);
      chk("t1_stall_e",  16'(fw_stall_e), 16'h0);
      tick();
      mid();
      chk("t1_release", 16'(fw_stall_d), 16'h0);
      tick();
      nop_d();
      mid();
      chk("t1_fwd_b", 16'(fw_fwd_b), 16'h2);
      chk("t1_fwd_a", 16'(fw_fwd_a), 16'h0);
      tick();
      nops(3);

      // 2: add r2 ; sub r5,r2,r2 -> both operands from M, no stall
      set_d(1, 2, 1, 1, 1, 1, 1, 0, 0);
      tick();
      set_d(1, 5, 1, 2, 1, 2, 1, 0, 0);
      mid();
      chk("t2_no_stall", 16'(fw_stall_d), 16'h0);
      tick();
      nop_d();
      mid();
      chk("t2_fwd_a", 16'(fw_fwd_a), 16'h1);
      chk("t2_fwd_b", 16'(fw_fwd_b), 16'h1);
      tick();
      nops(3);

      // 3: r2 writers in both M and W -> M wins
      set_d(1, 2, 1, 1, 1, 1, 1, 0, 0);
      tick();
      set_d(1, 2, 1, 7, 1, 7, 1, 0, 0);
      tick();
      set_d(1, 6, 1, 2, 1, 0, 1, 0, 0);
      tick();
      nop_d();
      mid();
      chk("t3_fwd_a", 16'(fw_fwd_a), 16'h1);
      chk("t3_fwd_b", 16'(fw_fwd_b), 16'h0);
      tick();
      nops(3);

      // 4: mul enters E -> freeze exactly MUL_LAT-1 = 2 cycles
      set_d(1, 8, 1, 1, 1, 1, 1, 0, 1);
      mid();
      chk("t4_pre", 16'(fw_stall_e), 16'h0);
      tick();
      nop_d();
      n_all = 0;
      n_any = 0;
      for (int i = 0; i < 6; i++) begin
         mid();
         if (fw_stall_f && fw_stall_d && fw_stall_e && fw_bubble_m) n_all++;
         if (fw_stall_f || fw_stall_d || fw_stall_e || fw_bubble_m) n_any++;
         tick();
      end
      chk("t4_freeze_all", 16'(n_all), 16'd2);
      chk("t4_freeze_any", 16'(n_any), 16'd2);
      nops(3);

      // 5: load-use in D while branch taken in EX -> flush wins
      set_d(1, 2, 1, 1, 1, 0, 0, 1, 0);
      tick();
      set_d(1, 3, 1, 4, 1, 2, 1, 0, 0);
      BranchTakenE = 1'b1;
      mid();
      chk("t5_flush_d",  16'(fw_flush_d),  16'h1);
      chk("t5_bubble_e", 16'(fw_bubble_e), 16'h1);
      chk("t5_stall_f",  16'(fw_stall_f),  16'h0);
      chk("t5_stall_d",  16'(fw_stall_d),  16'h0);
      tick();
      BranchTakenE = 1'b0;
      nops(3);

      // 6: r0 as destination and source -> no stall, no forward
      set_d(1, 0, 1, 1, 1, 0, 0, 1, 0);
      tick();
      set_d(1, 3, 1, 0, 1, 0, 1, 0, 0);
      mid();
      chk("t6_fw_stall", 16'(fw_stall_d), 16'h0);
      chk("t6_nf_stall", 16'(nf_stall_d), 16'h0);
      tick();
      nop_d();
      mid();
      chk("t6_fwd_a", 16'(fw_fwd_a), 16'h0);
      chk("t6_fwd_b", 16'(fw_fwd_b), 16'h0);
      tick();
      nops(3);

      // 7: FWD_EN=0 RAW -> stall until writer leaves W (3 cycles)
      set_d(1, 9, 1, 1, 1, 1, 1, 0, 0);
      tick();
      set_d(1, 10, 1, 9, 1, 1, 1, 0, 0);
      n_any = 0;
      for (int i = 0; i < 6; i++) begin
         mid();
         if (nf_stall_d) n_any++;
         if (i == 0) begin
            chk("t7_nf_bubble_e", 16'(nf_bubble_e), 16'h1);
            chk("t7_nf_stall_e",  16'(nf_stall_e),  16'h0);
            chk("t7_fw_no_stall", 16'(fw_stall_d),  16'h0);
         end
         tick();
      end
      chk("t7_raw_len", 16'(n_any), 16'd3);
      nops(3);

      // 8: reset in the middle of a multiply freeze
      set_d(1, 8, 1, 1, 1, 1, 1, 0, 1);
      tick();
      nop_d();
      mid();
      chk("t8_busy", 16'(fw_stall_e), 16'h1);
      @(posedge Clock); #3;
      nReset = 1'b0;
      #1;
      chk("t8_rst_fw", 16'(got_fw), 16'h0);
      chk("t8_rst_nf", 16'(got_nf), 16'h0);
      @(posedge Clock); #3;
      nReset = 1'b1;
      n_any = 0;
      for (int i = 0; i < 4; i++) begin
         mid();
         if (fw_stall_f || fw_stall_e || fw_bubble_m || nf_stall_f || nf_stall_e) n_any++;
         tick();
      end
      chk("t8_no_stall_after", 16'(n_any), 16'd0);

      nops(2);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
